// File: rtl/rom_arbiter_if.sv
// Bus bundle between the two ROM requesters (fetch, debug), the shared ROM and rom_arbiter.
// The master side is the requesters plus the ROM. The slave side is the arbiter.
interface rom_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic          gnt0;
    logic          rvalid0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic [AW-1:0] addr1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata1;

    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;

    modport master (
        output req0, addr0, req1, addr1, rom_data,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr
    );

    modport slave (
        input  req0, addr0, req1, addr1, rom_data,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port arbiter sharing one combinational ROM: stage A grants and registers the address, stage B captures the word.
// Build option ROM_ARB_RR_EN: round-robin instead of port-0 priority with a port-1 starvation limit.
module rom_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    rom_arbiter_if.slave  bus
);

    logic [1:0]    req_v;
    logic [1:0]    gnt_next;
    logic [AW-1:0] rom_addr_reg;
    logic          vld_a_reg;
    logic          sel_a_reg;

    assign req_v = {bus.req1, bus.req0};

`ifdef ROM_ARB_RR_EN
    logic rr_ptr_reg;
    logic rr_ptr_next;

    // The preferred port wins a tie. The pointer moves only when the preferred port is served.
    always_comb begin
        gnt_next    = 2'b00;
        rr_ptr_next = rr_ptr_reg;
        if (req_v[rr_ptr_reg]) begin
            gnt_next[rr_ptr_reg] = 1'b1;
            rr_ptr_next          = ~rr_ptr_reg;
        end else if (req_v[~rr_ptr_reg]) begin
            gnt_next[~rr_ptr_reg] = 1'b1;
        end
        if (rst) begin
            gnt_next    = 2'b00;
            rr_ptr_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= 1'b0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
`else
    logic [3:0] starve_cnt_reg;
    logic [3:0] starve_cnt_next;

    // Port 0 wins unless port 1 has already lost STARVE_MAX cycles in a row.
    always_comb begin
        gnt_next        = 2'b00;
        starve_cnt_next = starve_cnt_reg;
        if (bus.req1 && (!bus.req0 || starve_cnt_reg == 4'(STARVE_MAX))) begin
            gnt_next[1] = 1'b1;
        end else if (bus.req0) begin
            gnt_next[0] = 1'b1;
        end
        if (gnt_next[1] || !bus.req1) begin
            starve_cnt_next = 4'd0;
        end else if (gnt_next[0]) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
        if (rst) begin
            gnt_next        = 2'b00;
            starve_cnt_next = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= 4'd0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end
`endif

    assign bus.gnt0     = gnt_next[0];
    assign bus.gnt1     = gnt_next[1];
    assign bus.rom_addr = rom_addr_reg;

    // Stage A: the winning address goes onto the ROM. The address holds while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_reg <= '0;
            vld_a_reg    <= 1'b0;
            sel_a_reg    <= 1'b0;
        end else if (|gnt_next) begin
            rom_addr_reg <= gnt_next[1] ? bus.addr1 : bus.addr0;
            sel_a_reg    <= gnt_next[1];
            vld_a_reg    <= 1'b1;
        end else begin
            vld_a_reg    <= 1'b0;
        end
    end

    // Stage B: one capture register per port. The port that was not selected keeps its last word.
    for (genvar gi = 0; gi < 2; gi++) begin : port_g
        logic [DW-1:0] rdata_reg;
        logic          rvalid_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_reg  <= '0;
                rvalid_reg <= 1'b0;
            end else begin
                rvalid_reg <= vld_a_reg && (sel_a_reg == 1'(gi));
                if (vld_a_reg && (sel_a_reg == 1'(gi))) begin
                    rdata_reg <= bus.rom_data;
                end
            end
        end
    end

    assign bus.rdata0  = port_g[0].rdata_reg;
    assign bus.rvalid0 = port_g[0].rvalid_reg;
    assign bus.rdata1  = port_g[1].rdata_reg;
    assign bus.rvalid1 = port_g[1].rvalid_reg;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed and random bench for rom_arbiter. A transaction-level reference model supplies every expected value.
module tb_rom_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SM = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rom_arbiter_if #(.AW(AW), .DW(DW)) bus();
    rom_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DW-1:0] rom_mem [1<<AW];
    assign bus.rom_data = rom_mem[bus.rom_addr];

    int errors = 0;
    int checks = 0;

    // Reference model. It keeps the count of consecutive port-1 losses, or the preferred port, and a two-deep queue of reads in flight.
    int            lose_cnt;
    bit            pref;
    bit            p1_vld, p2_vld;
    bit            p1_port, p2_port;
    logic [AW-1:0] p1_addr, p2_addr;
    logic [DW-1:0] exp_rdata [2];
    logic [AW-1:0] exp_rom_addr;
    int            nv0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        lose_cnt     = 0;
        pref         = 1'b0;
        p1_vld       = 1'b0;
        p2_vld       = 1'b0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        exp_rom_addr = '0;
    endtask

    function automatic logic [1:0] winner();
        logic [1:0] r;
        r = {bus.req1, bus.req0};
`ifdef ROM_ARB_RR_EN
        if (r[pref])       return pref ? 2'b10 : 2'b01;
        else if (r[~pref]) return pref ? 2'b01 : 2'b10;
        else               return 2'b00;
`else
        if (r[1] && (!r[0] || lose_cnt == SM)) return 2'b10;
        else if (r[0])                         return 2'b01;
        else                                   return 2'b00;
`endif
    endfunction

    // One clock cycle. It is entered and left at posedge+1, with the inputs already driven.
    task automatic cycle(output logic [1:0] g);
        logic [1:0] w;
        w = winner();
        @(negedge clk);
        check("gnt0", bus.gnt0, w[0]);
        check("gnt1", bus.gnt1, w[1]);
        check("rvalid0", bus.rvalid0, p2_vld && !p2_port);
        check("rvalid1", bus.rvalid1, p2_vld && p2_port);
        check("rdata0", bus.rdata0, exp_rdata[0]);
        check("rdata1", bus.rdata1, exp_rdata[1]);
        check("rom_addr", bus.rom_addr, exp_rom_addr);
        if (bus.rvalid0) nv0++;
        @(posedge clk);
        p2_vld  = p1_vld;
        p2_port = p1_port;
        p2_addr = p1_addr;
        p1_vld  = (w != 2'b00);
        p1_port = w[1];
        p1_addr = w[1] ? bus.addr1 : bus.addr0;
        if (p1_vld) exp_rom_addr = p1_addr;
        if (p2_vld) exp_rdata[p2_port] = rom_mem[p2_addr];
`ifdef ROM_ARB_RR_EN
        if (w[pref]) pref = ~pref;
`else
        if (w[0] && bus.req1) lose_cnt++;
        else                  lose_cnt = 0;
`endif
        #1;
        g = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
        check("rst_rvalid", {bus.rvalid1, bus.rvalid0}, 2'b00);
        check("rst_rom_addr", bus.rom_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] g;
        for (int i = 0; i < (1 << AW); i++) rom_mem[i] = $urandom;
        bus.req0 = 1'b0; bus.addr0 = '0;
        bus.req1 = 1'b0; bus.addr1 = '0;
        model_reset();
        #2;
        check("init_rdata0", bus.rdata0, 0);
        check("init_rdata1", bus.rdata1, 0);
        do_reset();

        // Single read on port 0.
        bus.req0 = 1'b1; bus.addr0 = 10'h005;
        cycle(g);
        $display("single: gnt=%b addr=%h", g, 10'h005);
        bus.req0 = 1'b0;
        check("single_rom_addr", bus.rom_addr, 10'h005);
        cycle(g);
        check("single_rvalid0", bus.rvalid0, 1'b1);
        check("single_rdata0", bus.rdata0, rom_mem[5]);
        cycle(g);
        cycle(g);

        // Stream of ten port-0 reads, addresses 0 to 9.
        nv0 = 0;
        bus.req0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.addr0 = AW'(i);
            cycle(g);
        end
        bus.req0 = 1'b0;
        for (int i = 0; i < 3; i++) cycle(g);
        check("stream_count", nv0, 10);
        $display("stream: rvalid0 pulses=%0d", nv0);

        // Both ports request continuously.
        do_reset();
        bus.req0 = 1'b1; bus.addr0 = 10'h100;
        bus.req1 = 1'b1; bus.addr1 = 10'h3FF;
        for (int i = 0; i < 12; i++) begin
            #1;
`ifdef ROM_ARB_RR_EN
            check("cont_gnt1", bus.gnt1, (i % 2) == 1);
`else
            check("cont_gnt1", bus.gnt1, (i % (SM + 1)) == SM);
`endif
            cycle(g);
            $display("contention %0d: gnt=%b", i, g);
            if (g[0]) bus.addr0 = bus.addr0 + 10'd1;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        for (int i = 0; i < 3; i++) cycle(g);
        check("cont_rdata1", bus.rdata1, rom_mem[10'h3FF]);

        // Random traffic. A request and its address stay unchanged until the request is granted.
        for (int i = 0; i < 300; i++) begin
            if (!bus.req0 && $urandom_range(1) == 1) begin bus.req0 = 1'b1; bus.addr0 = AW'($urandom); end
            if (!bus.req1 && $urandom_range(1) == 1) begin bus.req1 = 1'b1; bus.addr1 = AW'($urandom); end
            cycle(g);
            if (g[0]) begin
                if ($urandom_range(1) == 1) bus.addr0 = AW'($urandom);
                else                        bus.req0 = 1'b0;
            end
            if (g[1]) begin
                if ($urandom_range(1) == 1) bus.addr1 = AW'($urandom);
                else                        bus.req1 = 1'b0;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        for (int i = 0; i < 3; i++) cycle(g);
        $display("random: 300 cycles done");

        // Twenty idle cycles.
        for (int i = 0; i < 20; i++) cycle(g);
        $display("idle: rom_addr=%h", bus.rom_addr);

        // Reset asserted while a granted read is still in flight.
        bus.req0 = 1'b1; bus.addr0 = 10'h2A5;
        cycle(g);
        bus.req0 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rom_addr", bus.rom_addr, 0);
        check("mid_rvalid", {bus.rvalid1, bus.rvalid0}, 2'b00);
        check("mid_rdata0", bus.rdata0, 0);
        check("mid_rdata1", bus.rdata1, 0);
        check("mid_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < 5; i++) cycle(g);
        $display("reset mid-flight: rvalid after release=%b", {bus.rvalid1, bus.rvalid0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares the single combinational instruction ROM (10-bit address, 32-bit data) between the pipeline fetch stage (port 0) and the board debug/display reader (port 1). Each cycle it grants at most one request, registers the winning address onto the ROM, captures the ROM word one cycle later, and returns it to the winner with a valid strobe. It sits between the IF stage, the debug reader and the `Rom` instance in the PipelineCPU top level.

## Interface
- `AW`, default 10: ROM address width.
- `DW`, default 32: ROM data width.
- `STARVE_MAX`, default 8: consecutive lost arbitration cycles after which port 1 is forced to win. Legal range is 1..15; the counter is 4 bits.

Ports (name, direction, width, meaning):
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req0` input 1: port 0 (fetch) request.
- `addr0` input AW: port 0 address; must be held stable while `req0` is high until granted.
- `gnt0` output 1: port 0 grant; combinational in the cycle the request is accepted.
- `rvalid0` output 1: one-cycle strobe; `rdata0` is valid.
- `rdata0` output DW: port 0 read data.
- `req1`, `addr1`, `gnt1`, `rvalid1`, `rdata1`: same signals for port 1 (debug).
- `rom_addr` output AW: registered address driven to the ROM.
- `rom_data` input DW: combinational ROM output for `rom_addr`.

## Operation
- The arbiter has two pipeline stages:
  - A (accept): arbitrate and register the address.
  - B (capture): register `rom_data`.
- At most one grant per cycle; `gnt0 & gnt1` is never 1. No grant is issued without a request.
- Default policy (macro undefined) is fixed priority, port 0 first.
  - `starve_cnt` increments on every cycle with `req1 & gnt0`.
  - `starve_cnt` clears on `gnt1` or when `!req1`.
  - When `starve_cnt == STARVE_MAX` and `req1` is high, port 1 wins even if `req0` is high.
- On a grant, the selected address is loaded into `rom_addr` and `sel_a <= port`, `vld_a <= 1`. Otherwise `rom_addr` holds its value and `vld_a <= 0`.
- Stage B: when `vld_a` is set, `rom_data` is copied into `rdata[sel_a]` and `rvalid[sel_a]` pulses for one cycle. The other port's `rdata` holds its value.
- Back-to-back grants are fully pipelined, giving one word per cycle of throughput.
- Reset values:
  - `rom_addr` = 0, `rdata0` = `rdata1` = 0, `rvalid0` = `rvalid1` = 0.
  - `vld_a` = 0, `sel_a` = 0, `starve_cnt` = 0, `rr_ptr` = 0.
  - `gnt0` = `gnt1` = 0 while `rst` is high.
- Reset asserted mid-operation discards in-flight stage-A/B reads; no `rvalid` is produced for them after release.

## Timing
- Cycle N: `req` is high and wins, so `gnt` is high in N. The address is latched at the edge ending N.
- Cycle N+1: the ROM presents `rom_data`. It is captured at the edge ending N+1.
- Cycle N+2: `rvalid` = 1 with `rdata`. Latency from grant to data is 2 cycles.
- A requester that is not granted keeps `req` and `addr` held; the arbiter has no request buffering.
- A requester may drop `req` in N+1 after a grant, or keep it high to issue the next address.
- With both ports requesting continuously under the default policy, port 1 wins exactly once every `STARVE_MAX+1` cycles.

## Configuration
- `ROM_ARB_RR_EN` defined: the fixed-priority and starvation logic is removed and replaced by round robin.
  - The 1-bit `rr_ptr` names the preferred port and toggles after every grant to the preferred port.
  - With simultaneous requests, the preferred port wins; with a single request, that request wins.
- `ROM_ARB_RR_EN` undefined: fixed priority with the starvation counter as described above; `rr_ptr` is absent.

## Test plan
- Single read, port 0 only: ROM preloaded, `req0`=1 for 1 cycle with `addr0`=0x005. Required: `gnt0` in N, `rom_addr`=0x005 in N+1, `rvalid0`=1 with `rdata0`=ROM[5] in N+2, `rvalid1` never high.
- Streaming, port 0 only: `req0` held high for 10 cycles, `addr0` incrementing 0..9. Required: 10 consecutive `rvalid0` pulses with ROM[0..9] in order, starting 2 cycles after the first grant.
- Contention, default build with `STARVE_MAX`=3: `req0`=`req1`=1 held. Required: grant sequence 0,0,0,1 repeating, and port 1 data for `addr1`=0x3FF returned as ROM[0x3FF].
- Contention, `ROM_ARB_RR_EN` build: both requests held. Required: grants alternate 0,1,0,1 starting with port 0 after reset.
- Reset mid-flight: assert `rst` asynchronously in cycle N+1 of a granted read. Required: all outputs go to 0 immediately, and no `rvalid` follows release.
- Idle: `req0`=`req1`=0 for 20 cycles. Required: no grants, `rom_addr` unchanged, `rvalid` low throughout.
